// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, interrupt line
// numbers and a byte-enable merge helper.
package irq_ctrl_pkg;

    localparam logic [31:0] REG_MTIME_LO    = 32'h00;
    localparam logic [31:0] REG_MTIME_HI    = 32'h04;
    localparam logic [31:0] REG_MTIMECMP_LO = 32'h08;
    localparam logic [31:0] REG_MTIMECMP_HI = 32'h0C;
    localparam logic [31:0] REG_PENDING     = 32'h10;
    localparam logic [31:0] REG_ENABLE      = 32'h14;
    localparam logic [31:0] REG_MSIP        = 32'h18;
    localparam logic [31:0] REG_PRESCALE    = 32'h1C;

    localparam int IRQ_MSIP      = 3;
    localparam int IRQ_MTIP      = 7;
    localparam int IRQ_FAST_BASE = 16;

    localparam logic [31:0] IRQ_MASK = 32'hFFFF_0088;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Single-cycle register port between a bus master and the interrupt controller.
interface irq_ctrl_if #(parameter int ADDR_WIDTH = 5);

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic                  gnt;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic                  err;

    modport master (output req, we, addr, wdata, be,
                    input  gnt, rvalid, rdata, err);

    modport slave  (input  req, we, addr, wdata, be,
                    output gnt, rvalid, rdata, err);

endinterface

// File: rtl/irq_ctrl_timer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with per-half write ports and a
// registered MTIP compare.
module irq_ctrl_timer
    import irq_ctrl_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        wdata_i,
    input  logic [3:0]         be_i,
    input  logic               we_mtime_lo_i,
    input  logic               we_mtime_hi_i,
    input  logic               we_cmp_lo_i,
    input  logic               we_cmp_hi_i,
    input  logic               we_presc_i,
    output logic [63:0]        mtime_o,
    output logic [63:0]        mtimecmp_o,
    output logic [PRESC_W-1:0] presc_o,
    output logic               mtip_o
);

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q, cmp_d;
    logic               mtip_q;
    logic               tick;

    always_comb begin
        // >= keeps the period bounded if PRESCALE is lowered below the running count
        tick    = (cnt_q >= presc_q);
        cnt_d   = tick ? '0 : cnt_q + PRESC_W'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (we_mtime_lo_i) mtime_d[31:0]  = be_merge(mtime_q[31:0], wdata_i, be_i);
        if (we_mtime_hi_i) mtime_d[63:32] = be_merge(mtime_q[63:32], wdata_i, be_i);
        cmp_d = cmp_q;
        if (we_cmp_lo_i) cmp_d[31:0]  = be_merge(cmp_q[31:0], wdata_i, be_i);
        if (we_cmp_hi_i) cmp_d[63:32] = be_merge(cmp_q[63:32], wdata_i, be_i);
        presc_d = we_presc_i ? PRESC_W'(be_merge(32'(presc_q), wdata_i, be_i)) : presc_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            presc_q <= '0;
            mtime_q <= '0;
            cmp_q   <= '1;
            mtip_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            mtip_q  <= (mtime_q >= cmp_q);
        end
    end

    assign mtime_o    = mtime_q;
    assign mtimecmp_o = cmp_q;
    assign presc_o    = presc_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: register decode, external edge detection, pending/enable
// state and the registered irq_o lines to the core.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_EXT    = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int PRESC_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    irq_ctrl_if.slave          reg_if,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    output logic [31:0]        irq_o,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_id_i
);

    localparam logic [31:0] EXT_MASK  = 32'((64'd1 << NUM_EXT) - 64'd1) << IRQ_FAST_BASE;
    localparam logic [31:0] IMPL_MASK = IRQ_MASK & (EXT_MASK | 32'h0000_0088);

    logic [63:0]        mtime, mtimecmp;
    logic [PRESC_W-1:0] presc;
    logic               mtip;

    logic [31:0]        addr32, rd_mux, pend_full;
    logic               wr, acc_ok;
    logic               we_mtime_lo, we_mtime_hi, we_cmp_lo, we_cmp_hi;
    logic               we_pend, we_en, we_msip, we_presc;
    logic [NUM_EXT-1:0] ext_q, ext_rise, clr_vec;
    logic [NUM_EXT-1:0] pend_q, pend_d;
    logic [31:0]        en_q, en_d, irq_q, irq_d, rdata_q, rdata_d;
    logic               msip_q, msip_d, rvalid_q, err_q, err_d;

    irq_ctrl_timer #(.PRESC_W(PRESC_W)) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wdata_i       (reg_if.wdata),
        .be_i          (reg_if.be),
        .we_mtime_lo_i (we_mtime_lo),
        .we_mtime_hi_i (we_mtime_hi),
        .we_cmp_lo_i   (we_cmp_lo),
        .we_cmp_hi_i   (we_cmp_hi),
        .we_presc_i    (we_presc),
        .mtime_o       (mtime),
        .mtimecmp_o    (mtimecmp),
        .presc_o       (presc),
        .mtip_o        (mtip)
    );

    always_comb begin
        pend_full                          = '0;
        pend_full[IRQ_MSIP]                = msip_q;
        pend_full[IRQ_MTIP]                = mtip;
        pend_full[IRQ_FAST_BASE +: NUM_EXT] = pend_q;

        addr32      = 32'(reg_if.addr);
        wr          = reg_if.req & reg_if.we;
        acc_ok      = 1'b1;
        rd_mux      = '0;
        we_mtime_lo = 1'b0;
        we_mtime_hi = 1'b0;
        we_cmp_lo   = 1'b0;
        we_cmp_hi   = 1'b0;
        we_pend     = 1'b0;
        we_en       = 1'b0;
        we_msip     = 1'b0;
        we_presc    = 1'b0;
        // misaligned addresses never match an offset and fall into default
        case (addr32)
            REG_MTIME_LO:    begin rd_mux = mtime[31:0];     we_mtime_lo = wr; end
            REG_MTIME_HI:    begin rd_mux = mtime[63:32];    we_mtime_hi = wr; end
            REG_MTIMECMP_LO: begin rd_mux = mtimecmp[31:0];  we_cmp_lo   = wr; end
            REG_MTIMECMP_HI: begin rd_mux = mtimecmp[63:32]; we_cmp_hi   = wr; end
            REG_PENDING:     begin rd_mux = pend_full;       we_pend     = wr; end
            REG_ENABLE:      begin rd_mux = en_q;            we_en       = wr; end
            REG_MSIP:        begin rd_mux = 32'(msip_q);     we_msip     = wr; end
            REG_PRESCALE:    begin rd_mux = 32'(presc);      we_presc    = wr; end
            default:         acc_ok = 1'b0;
        endcase

        rdata_d = (reg_if.req && !reg_if.we && acc_ok) ? rd_mux : '0;
        err_d   = reg_if.req & ~acc_ok;

        ext_rise = ext_irq_i & ~ext_q;
        clr_vec  = we_pend ? NUM_EXT'(be_merge('0, reg_if.wdata, reg_if.be) >> IRQ_FAST_BASE) : '0;
        for (int k = 0; k < NUM_EXT; k++) begin
            if (irq_ack_i && irq_id_i == 5'(IRQ_FAST_BASE + k)) clr_vec[k] = 1'b1;
        end
        // a new edge wins over a simultaneous ack or W1C
        pend_d = (pend_q & ~clr_vec) | ext_rise;

        en_d   = we_en ? (be_merge(en_q, reg_if.wdata, reg_if.be) & IMPL_MASK) : en_q;
        msip_d = (we_msip && reg_if.be[0]) ? reg_if.wdata[0] : msip_q;
        irq_d  = pend_full & en_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ext_q    <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            msip_q   <= 1'b0;
            irq_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ext_q    <= ext_irq_i;
            pend_q   <= pend_d;
            en_q     <= en_d;
            msip_q   <= msip_d;
            irq_q    <= irq_d;
            rvalid_q <= reg_if.req;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign reg_if.gnt    = reg_if.req;
    assign reg_if.rvalid = rvalid_q;
    assign reg_if.rdata  = rdata_q;
    assign reg_if.err    = err_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register responses are checked through a scoreboard
// queue, irq_o timing is checked at fixed points in the stimulus.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ext;
    logic [31:0] irq;
    logic        ack;
    logic [4:0]  id;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sb[$];

    irq_ctrl_if #(.ADDR_WIDTH(6)) reg_if ();

    irq_ctrl #(.NUM_EXT(16), .ADDR_WIDTH(6), .PRESC_W(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .reg_if    (reg_if),
        .ext_irq_i (ext),
        .irq_o     (irq),
        .irq_ack_i (ack),
        .irq_id_i  (id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // response monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (reg_if.req === 1'b1) begin
            n_cmp++;
            assert (reg_if.gnt === 1'b1) else begin
                n_bad++;
                $error("FAIL gnt: observed %b expected 1", reg_if.gnt);
            end
        end
        if (rst === 1'b0 && reg_if.rvalid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $error("FAIL unexpected_rvalid: observed rvalid=1 expected no response");
            end else begin
                e = sb.pop_front();
                assert (reg_if.rdata === e.rdata && reg_if.err === e.err) else begin
                    n_bad++;
                    $error("FAIL %s: observed rdata=%h err=%b expected rdata=%h err=%b",
                           e.tag, reg_if.rdata, reg_if.err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [5:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] er, input logic ee,
                       input string tag);
        reg_if.req   = 1'b1;
        reg_if.we    = we;
        reg_if.addr  = a;
        reg_if.wdata = wd;
        reg_if.be    = be;
        sb.push_back('{er, ee, tag});
        @(posedge clk);
        #1;
        reg_if.req = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] er, input logic ee, input string tag);
        acc(1'b0, a, 32'h0, 4'h0, er, ee, tag);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] wd, input string tag);
        acc(1'b1, a, wd, 4'hF, 32'h0, 1'b0, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        rst          = 1'b1;
        ext          = '0;
        ack          = 1'b0;
        id           = '0;
        reg_if.req   = 1'b0;
        reg_if.we    = 1'b0;
        reg_if.addr  = '0;
        reg_if.wdata = '0;
        reg_if.be    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_irq", irq, 32'h0);
        chk("reset_rvalid", 32'(reg_if.rvalid), 32'h0);
        rst = 1'b0;

        // reset values; MTIME_LO is read at the first edge after reset release
        rd(6'h00, 32'h0, 1'b0, "rst_mtime_lo");
        rd(6'h04, 32'h0, 1'b0, "rst_mtime_hi");
        rd(6'h08, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
        rd(6'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
        rd(6'h10, 32'h0, 1'b0, "rst_pending");
        rd(6'h14, 32'h0, 1'b0, "rst_enable");
        rd(6'h18, 32'h0, 1'b0, "rst_msip");
        rd(6'h1C, 32'h0, 1'b0, "rst_prescale");
        rd(6'h20, 32'h0, 1'b1, "err_unmapped");
        rd(6'h02, 32'h0, 1'b1, "err_misaligned");
        acc(1'b1, 6'h1E, 32'h5, 4'hF, 32'h0, 1'b1, "err_wr_misaligned");
        rd(6'h1C, 32'h0, 1'b0, "prescale_unchanged");

        // timer compare with prescale 3
        wr(6'h1C, 32'd3, "wr_prescale3");
        rd(6'h1C, 32'd3, 1'b0, "rd_prescale3");
        wr(6'h14, 32'h80, "wr_enable_mtip");
        wr(6'h04, 32'h0, "wr_mtime_hi0");
        wr(6'h00, 32'h0, "wr_mtime_lo0");
        wr(6'h08, 32'd10, "wr_cmp_lo10");
        wr(6'h0C, 32'h0, "wr_cmp_hi0");
        chk("mtip_low_after_setup", 32'(irq[7]), 32'h0);
        cyc = 0;
        while (irq[7] !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mtip_rise", 32'(irq[7]), 32'h1);
        chk("mtip_window", 32'(cyc >= 25 && cyc <= 50), 32'h1);
        rd(6'h10, 32'h80, 1'b0, "pending_mtip_mirror");
        wr(6'h0C, 32'h1, "wr_cmp_hi1");
        idle(3);
        chk("mtip_drop", 32'(irq[7]), 32'h0);
        rd(6'h10, 32'h0, 1'b0, "pending_mtip_clear");

        // external edge -> irq at n+2, ack clears
        wr(6'h14, 32'h0003_0000, "wr_enable_ext");
        ext[0] = 1'b1;
        idle(1);
        ext[0] = 1'b0;
        chk("ext16_n1", 32'(irq[16]), 32'h0);
        idle(1);
        chk("ext16_n2", 32'(irq[16]), 32'h1);
        ack = 1'b1;
        id  = 5'd16;
        idle(1);
        ack = 1'b0;
        idle(1);
        chk("ext16_acked", 32'(irq[16]), 32'h0);

        // set beats a simultaneous ack; held level does not re-trigger
        ext[1] = 1'b1;
        ack    = 1'b1;
        id     = 5'd17;
        idle(1);
        ack = 1'b0;
        idle(2);
        chk("ext17_set_wins", 32'(irq[17]), 32'h1);
        rd(6'h10, 32'h0002_0000, 1'b0, "pending17");
        wr(6'h10, 32'h0002_0000, "w1c17");
        idle(3);
        rd(6'h10, 32'h0, 1'b0, "pending_level_no_retrigger");
        chk("irq_after_w1c", irq, 32'h0);

        // pending without enable, partial byte-enable W1C
        ext[2] = 1'b1;
        idle(1);
        ext[2] = 1'b0;
        idle(2);
        chk("ext18_not_enabled", irq, 32'h0);
        rd(6'h10, 32'h0004_0000, 1'b0, "pending18");
        acc(1'b1, 6'h10, 32'h0004_0000, 4'b0011, 32'h0, 1'b0, "w1c_be_low");
        rd(6'h10, 32'h0004_0000, 1'b0, "pending18_kept");
        wr(6'h10, 32'hFFFF_FFFF, "w1c_all");
        rd(6'h10, 32'h0, 1'b0, "pending_cleared");
        wr(6'h14, 32'hFFFF_FFFF, "wr_enable_all");
        rd(6'h14, 32'hFFFF_0088, 1'b0, "enable_mask");
        ext = '0;

        // carry from LO into HI, HI write during increment, 64-bit wrap
        wr(6'h1C, 32'h0, "wr_prescale0");
        wr(6'h04, 32'h0, "wr_mtime_hi_0");
        wr(6'h00, 32'hFFFF_FFFF, "wr_mtime_lo_ff");
        idle(1);
        rd(6'h04, 32'h1, 1'b0, "mtime_carry");
        wr(6'h04, 32'h5, "wr_mtime_hi5");
        rd(6'h04, 32'h5, 1'b0, "mtime_hi_written");
        wr(6'h04, 32'hFFFF_FFFF, "wr_mtime_hi_ff");
        wr(6'h00, 32'hFFFF_FFFF, "wr_mtime_lo_ff2");
        idle(1);
        rd(6'h04, 32'h0, 1'b0, "mtime_wrap");
        idle(3);

        // software interrupt; ack of id 3 has no effect
        wr(6'h18, 32'h1, "wr_msip");
        idle(1);
        chk("msip_irq", 32'(irq[3]), 32'h1);
        ack = 1'b1;
        id  = 5'd3;
        idle(1);
        ack = 1'b0;
        idle(2);
        chk("msip_ack_ignored", 32'(irq[3]), 32'h1);
        chk("unimpl_bits_zero", irq & 32'h0000_FF77, 32'h0);
        rd(6'h18, 32'h1, 1'b0, "rd_msip1");
        idle(1);

        // reset during a read drops the response
        reg_if.req  = 1'b1;
        reg_if.we   = 1'b0;
        reg_if.addr = 6'h18;
        #2;
        rst = 1'b1;
        #5;
        chk("rst_mid_rvalid", 32'(reg_if.rvalid), 32'h0);
        chk("rst_mid_irq", irq, 32'h0);
        reg_if.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("post_rst_rvalid", 32'(reg_if.rvalid), 32'h0);
        chk("post_rst_irq", irq, 32'h0);
        rd(6'h18, 32'h0, 1'b0, "post_rst_msip");
        rd(6'h14, 32'h0, 1'b0, "post_rst_enable");
        idle(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
